// File: rtl/mux_tree_sequencer.sv
// Break-before-make sequencer for a binary-tree fluidic multiplexer.
// Accepts route/flush requests over valid/ready and drives per-level
// control-line pairs (1 = pressurised = valve closed). Every path change
// closes all valves and lets the fabric settle before the new path opens.
module mux_tree_sequencer #(
  parameter int LEVELS        = 5,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_flush,
  input  logic [LEVELS-1:0] req_addr,
  output logic [LEVELS-1:0] ctrl_0,
  output logic [LEVELS-1:0] ctrl_1,
  output logic              path_valid,
  output logic [LEVELS-1:0] active_addr,
  output logic              done
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CLOSE, OPEN, ACTIVE} state_t;

  state_t            state, state_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [LEVELS-1:0] tgt, tgt_n;
  logic              flush_q, flush_n;
  logic              done_pend, done_pend_n;
  logic [LEVELS-1:0] ctrl_0_n, ctrl_1_n, active_addr_n;
  logic              path_valid_n, done_n;
  logic [LEVELS-1:0] req_pat, tgt_pat;
  logic              accept;

  // Level i (index) is steered by address bit LEVELS-1-i; ctrl_0 closes the
  // side not selected, so ctrl_0 is the bit-reversed address.
  function automatic logic [LEVELS-1:0] closed_side0(input logic [LEVELS-1:0] a);
    logic [LEVELS-1:0] r;
    for (int i = 0; i < LEVELS; i++) r[i] = a[LEVELS-1-i];
    return r;
  endfunction

  assign req_pat   = closed_side0(req_addr);
  assign tgt_pat   = closed_side0(tgt);
  assign req_ready = (state == IDLE) || (state == ACTIVE);
  assign accept    = req_valid && req_ready;

  // Next-state and next-output logic; registered outputs hold by default.
  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    tgt_n         = tgt;
    flush_n       = flush_q;
    done_pend_n   = 1'b0;
    ctrl_0_n      = ctrl_0;
    ctrl_1_n      = ctrl_1;
    path_valid_n  = path_valid;
    active_addr_n = active_addr;
    done_n        = done_pend;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (req_flush) begin
            done_pend_n = 1'b1;
          end else begin
            state_n  = OPEN;
            tgt_n    = req_addr;
            ctrl_0_n = req_pat;
            ctrl_1_n = ~req_pat;
            cnt_n    = CNT_LOAD;
          end
        end
      end
      ACTIVE: begin
        if (accept) begin
          if (!req_flush && (req_addr == active_addr)) begin
            done_pend_n = 1'b1;
          end else begin
            state_n      = CLOSE;
            flush_n      = req_flush;
            tgt_n        = req_addr;
            ctrl_0_n     = '1;
            ctrl_1_n     = '1;
            path_valid_n = 1'b0;
            cnt_n        = CNT_LOAD;
          end
        end
      end
      CLOSE: begin
        if (cnt == '0) begin
          if (flush_q) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n  = OPEN;
            ctrl_0_n = tgt_pat;
            ctrl_1_n = ~tgt_pat;
            cnt_n    = CNT_LOAD;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      OPEN: begin
        if (cnt == '0) begin
          state_n       = ACTIVE;
          path_valid_n  = 1'b1;
          active_addr_n = tgt;
          done_n        = 1'b1;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
    endcase
  end

  // State and output registers; reset closes every valve at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tgt         <= '0;
      flush_q     <= 1'b0;
      done_pend   <= 1'b0;
      ctrl_0      <= '1;
      ctrl_1      <= '1;
      path_valid  <= 1'b0;
      active_addr <= '0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      tgt         <= tgt_n;
      flush_q     <= flush_n;
      done_pend   <= done_pend_n;
      ctrl_0      <= ctrl_0_n;
      ctrl_1      <= ctrl_1_n;
      path_valid  <= path_valid_n;
      active_addr <= active_addr_n;
      done        <= done_n;
    end
  end

endmodule
